// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the Harvard-core to Avalon-MM bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_DREAD  = 2'd2,
    ST_DWRITE = 2'd3
  } state_t;

  localparam int MAX_ADDR_W = 64;

  // Clears the byte-offset bits of an address for a bus of data_w bits.
  function automatic logic [MAX_ADDR_W-1:0] word_align(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int data_w);
    logic [MAX_ADDR_W-1:0] v_mask;
    v_mask = ~((64'd1 << $clog2(data_w / 8)) - 64'd1);
    return addr & v_mask;
  endfunction

endpackage

// File: rtl/mips_ibuf.sv
// One-word instruction buffer: hit compare, fill on fetch, invalidate on
// a write to the buffered word and, optionally, on every advancing edge.
module mips_ibuf #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IBUF_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_wr_done,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_advance,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  assign o_hit  = r_valid && (r_addr == i_fetch_addr);
  assign o_data = r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_load_addr;
      r_data  <= i_load_data;
    end else if (i_wr_done && (r_addr == i_wr_addr)) begin
      r_valid <= 1'b0;
    end else if (i_advance && (IBUF_EN == 0)) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Serialises instruction fetches and data accesses from a stall-controlled
// Harvard core onto one Avalon-MM master, one transaction at a time.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int DATA_FIRST = 0,
  parameter  int IBUF_EN    = 1,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [BE_W-1:0]   d_byteenable,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              clk_enable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] writedata
);

  state_t            r_state, w_state_nxt;
  logic              r_read, w_read_nxt;
  logic              r_write, w_write_nxt;
  logic [ADDR_W-1:0] r_address, w_address_nxt;
  logic [BE_W-1:0]   r_byteenable, w_byteenable_nxt;
  logic [DATA_W-1:0] r_writedata, w_writedata_nxt;
  logic              r_d_done;
  logic [DATA_W-1:0] r_d_rdata;

  logic [ADDR_W-1:0] w_i_addr_al, w_d_addr_al;
  logic              w_hit, w_i_pend, w_d_pend, w_advance, w_complete;

  assign w_i_addr_al = ADDR_W'(word_align(MAX_ADDR_W'(i_address), DATA_W));
  assign w_d_addr_al = ADDR_W'(word_align(MAX_ADDR_W'(d_address), DATA_W));
  assign w_i_pend    = i_read && !w_hit;
  assign w_d_pend    = (d_read || d_write) && !r_d_done;
  assign w_advance   = !reset && !w_i_pend && !w_d_pend;
  assign w_complete  = (r_state != ST_IDLE) && !waitrequest;

  mips_ibuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IBUF_EN(IBUF_EN)
  ) u_ibuf (
    .clk         (clk),
    .reset       (reset),
    .i_fetch_addr(w_i_addr_al),
    .i_load      (w_complete && (r_state == ST_IFETCH)),
    .i_load_addr (r_address),
    .i_load_data (readdata),
    .i_wr_done   (w_complete && (r_state == ST_DWRITE)),
    .i_wr_addr   (r_address),
    .i_advance   (w_advance),
    .o_hit       (w_hit),
    .o_data      (i_readdata)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_read_nxt       = r_read;
    w_write_nxt      = r_write;
    w_address_nxt    = r_address;
    w_byteenable_nxt = r_byteenable;
    w_writedata_nxt  = r_writedata;
    case (r_state)
      ST_IDLE: begin
        if (w_i_pend && (!w_d_pend || (DATA_FIRST == 0))) begin
          w_state_nxt      = ST_IFETCH;
          w_read_nxt       = 1'b1;
          w_address_nxt    = w_i_addr_al;
          w_byteenable_nxt = {BE_W{1'b1}};
        end else if (w_d_pend) begin
          w_address_nxt = w_d_addr_al;
          // A simultaneous read and write request is served as a read.
          if (d_read) begin
            w_state_nxt      = ST_DREAD;
            w_read_nxt       = 1'b1;
            w_byteenable_nxt = {BE_W{1'b1}};
          end else begin
            w_state_nxt      = ST_DWRITE;
            w_write_nxt      = 1'b1;
            w_byteenable_nxt = d_byteenable;
            w_writedata_nxt  = d_writedata;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IFETCH, ST_DREAD, ST_DWRITE: begin
        if (!waitrequest) begin
          w_state_nxt = ST_IDLE;
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= '0;
      r_byteenable <= '0;
      r_writedata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_read       <= w_read_nxt;
      r_write      <= w_write_nxt;
      r_address    <= w_address_nxt;
      r_byteenable <= w_byteenable_nxt;
      r_writedata  <= w_writedata_nxt;
    end
  end

  // d_done holds the data port released until the core takes its advancing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_done  <= 1'b0;
      r_d_rdata <= '0;
    end else if (w_complete && (r_state == ST_DREAD)) begin
      r_d_done  <= 1'b1;
      r_d_rdata <= readdata;
    end else if (w_complete && (r_state == ST_DWRITE)) begin
      r_d_done  <= 1'b1;
    end else if (w_advance) begin
      r_d_done  <= 1'b0;
    end else begin
      r_d_done  <= r_d_done;
    end
  end

  assign clk_enable = w_advance;
  assign d_readdata = r_d_rdata;
  assign read       = r_read;
  assign write      = r_write;
  assign address    = r_address;
  assign byteenable = r_byteenable;
  assign writedata  = r_writedata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench: three arbiters (fetch-first, data-first, no ibuf persistence)
// driven by shared core/slave stimulus, each checked against hand-derived cycles.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read_s;
  logic [31:0] i_addr_s;
  logic        d_read_s, d_write_s;
  logic [31:0] d_addr_s;
  logic [3:0]  d_be_s;
  logic [31:0] d_wd_s;
  logic        wait_s;
  logic [31:0] rdata_s;

  logic [31:0] i_rdata_s [3];
  logic [31:0] d_rdata_s [3];
  logic        ce_s      [3];
  logic        rd_s      [3];
  logic        wr_s      [3];
  logic [31:0] addr_s    [3];
  logic [3:0]  be_s      [3];
  logic [31:0] wd_s      [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_bus_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .DATA_FIRST((g == 1) ? 1 : 0),
      .IBUF_EN   ((g == 2) ? 0 : 1)
    ) dut (
      .clk         (clk),
      .reset       (rst),
      .i_read      (i_read_s),
      .i_address   (i_addr_s),
      .i_readdata  (i_rdata_s[g]),
      .d_read      (d_read_s),
      .d_write     (d_write_s),
      .d_address   (d_addr_s),
      .d_byteenable(d_be_s),
      .d_writedata (d_wd_s),
      .d_readdata  (d_rdata_s[g]),
      .clk_enable  (ce_s[g]),
      .waitrequest (wait_s),
      .readdata    (rdata_s),
      .read        (rd_s[g]),
      .write       (wr_s[g]),
      .address     (addr_s[g]),
      .byteenable  (be_s[g]),
      .writedata   (wd_s[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; i_read_s = 1'b0; i_addr_s = 32'd0; d_read_s = 1'b0; d_write_s = 1'b0;
    d_addr_s = 32'd0; d_be_s = 4'd0; d_wd_s = 32'd0; wait_s = 1'b0; rdata_s = 32'd0;

    // Reset values
    repeat (2) tick();
    #1;
    check_eq("rst_read", 64'(rd_s[0]), 64'd0);
    check_eq("rst_write", 64'(wr_s[0]), 64'd0);
    check_eq("rst_addr", 64'(addr_s[0]), 64'd0);
    check_eq("rst_be", 64'(be_s[0]), 64'd0);
    check_eq("rst_wd", 64'(wd_s[0]), 64'd0);
    check_eq("rst_ce", 64'(ce_s[0]), 64'd0);
    check_eq("rst_irdata", 64'(i_rdata_s[0]), 64'd0);
    check_eq("rst_drdata", 64'(d_rdata_s[0]), 64'd0);
    rst = 1'b0;
    tick();

    // Zero-wait fetch miss at the reset vector
    i_read_s = 1'b1; i_addr_s = 32'hBFC0_0000; rdata_s = 32'h2408_0001;
    #1;
    check_eq("f_n_ce", 64'(ce_s[0]), 64'd0);
    tick(); #1;
    check_eq("f_n1_read", 64'(rd_s[0]), 64'd1);
    check_eq("f_n1_addr", 64'(addr_s[0]), 64'hBFC0_0000);
    check_eq("f_n1_be", 64'(be_s[0]), 64'hF);
    check_eq("f_n1_ce", 64'(ce_s[0]), 64'd0);
    tick(); #1;
    check_eq("f_n2_read", 64'(rd_s[0]), 64'd0);
    check_eq("f_n2_ce", 64'(ce_s[0]), 64'd1);
    check_eq("f_n2_irdata", 64'(i_rdata_s[0]), 64'h2408_0001);
    check_eq("f_n2_ce_nb", 64'(ce_s[2]), 64'd1);

    // Same address held: buffer hits vs. refetch when persistence is off
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check_eq("hold_read", 64'(rd_s[0]), 64'd0);
      check_eq("hold_ce", 64'(ce_s[0]), 64'd1);
      if (k == 0) begin
        check_eq("nb_miss_ce", 64'(ce_s[2]), 64'd0);
        check_eq("nb_miss_read", 64'(rd_s[2]), 64'd0);
      end else if (k == 1) begin
        check_eq("nb_refetch", 64'(rd_s[2]), 64'd1);
      end
    end
    i_read_s = 1'b0;
    repeat (3) tick();

    // Fetch miss plus data write in the same cycle
    i_read_s = 1'b1; i_addr_s = 32'h0000_0100; rdata_s = 32'h0000_AAAA;
    d_write_s = 1'b1; d_addr_s = 32'h0000_2000; d_be_s = 4'hF; d_wd_s = 32'h1234_5678;
    #1;
    check_eq("both_n_ce", 64'(ce_s[0]), 64'd0);
    tick(); #1;
    check_eq("ff_n1_read", 64'(rd_s[0]), 64'd1);
    check_eq("ff_n1_addr", 64'(addr_s[0]), 64'h100);
    check_eq("ff_n1_write", 64'(wr_s[0]), 64'd0);
    check_eq("df_n1_write", 64'(wr_s[1]), 64'd1);
    check_eq("df_n1_addr", 64'(addr_s[1]), 64'h2000);
    check_eq("df_n1_wd", 64'(wd_s[1]), 64'h1234_5678);
    check_eq("df_n1_be", 64'(be_s[1]), 64'hF);
    tick(); #1;
    check_eq("ff_gap", 64'({rd_s[0], wr_s[0], ce_s[0]}), 64'd0);
    check_eq("df_gap", 64'({rd_s[1], wr_s[1], ce_s[1]}), 64'd0);
    tick(); #1;
    check_eq("ff_n3_write", 64'(wr_s[0]), 64'd1);
    check_eq("ff_n3_addr", 64'(addr_s[0]), 64'h2000);
    check_eq("ff_n3_wd", 64'(wd_s[0]), 64'h1234_5678);
    check_eq("df_n3_read", 64'(rd_s[1]), 64'd1);
    check_eq("df_n3_addr", 64'(addr_s[1]), 64'h100);
    check_eq("n3_ce", 64'({ce_s[0], ce_s[1]}), 64'd0);
    tick(); #1;
    check_eq("ff_n4_ce", 64'(ce_s[0]), 64'd1);
    check_eq("df_n4_ce", 64'(ce_s[1]), 64'd1);
    check_eq("ff_n4_irdata", 64'(i_rdata_s[0]), 64'h0000_AAAA);
    i_read_s = 1'b0; d_write_s = 1'b0;
    repeat (3) tick();

    // Data read stalled 5 cycles at an unaligned address
    wait_s = 1'b1; d_read_s = 1'b1; d_addr_s = 32'h0000_1003; rdata_s = 32'h1111_1111;
    #1;
    check_eq("dr_n_ce", 64'(ce_s[0]), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      check_eq("dr_wait_read", 64'(rd_s[0]), 64'd1);
      check_eq("dr_wait_addr", 64'(addr_s[0]), 64'h1000);
      check_eq("dr_wait_be", 64'(be_s[0]), 64'hF);
      check_eq("dr_wait_drdata", 64'(d_rdata_s[0]), 64'd0);
    end
    rdata_s = 32'hDEAD_BEEF; wait_s = 1'b0;
    tick(); #1;
    check_eq("dr_rel_read", 64'(rd_s[0]), 64'd0);
    check_eq("dr_rel_drdata", 64'(d_rdata_s[0]), 64'hDEAD_BEEF);
    check_eq("dr_rel_ce", 64'(ce_s[0]), 64'd1);
    d_read_s = 1'b0;
    repeat (2) tick();

    // Partial write to the buffered instruction word invalidates it
    i_read_s = 1'b1; i_addr_s = 32'h0000_0100; rdata_s = 32'hCAFE_0001;
    d_write_s = 1'b1; d_addr_s = 32'h0000_0102; d_be_s = 4'h1; d_wd_s = 32'h0000_00AB;
    #1;
    check_eq("coh_n_hitdata", 64'(i_rdata_s[0]), 64'h0000_AAAA);
    check_eq("coh_n_ce", 64'(ce_s[0]), 64'd0);
    tick(); #1;
    check_eq("coh_write", 64'(wr_s[0]), 64'd1);
    check_eq("coh_be", 64'(be_s[0]), 64'h1);
    check_eq("coh_addr", 64'(addr_s[0]), 64'h100);
    check_eq("coh_wd", 64'(wd_s[0]), 64'hAB);
    tick(); #1;
    check_eq("coh_n2_ce", 64'(ce_s[0]), 64'd0);
    check_eq("coh_n2_bus", 64'({rd_s[0], wr_s[0]}), 64'd0);
    tick(); #1;
    check_eq("coh_refetch", 64'(rd_s[0]), 64'd1);
    check_eq("coh_refetch_addr", 64'(addr_s[0]), 64'h100);
    tick(); #1;
    check_eq("coh_n4_ce", 64'(ce_s[0]), 64'd1);
    check_eq("coh_n4_irdata", 64'(i_rdata_s[0]), 64'hCAFE_0001);
    i_read_s = 1'b0; d_write_s = 1'b0;
    repeat (3) tick();

    // Reset during a stalled fetch
    wait_s = 1'b1; i_read_s = 1'b1; i_addr_s = 32'h0000_0200;
    tick(); #1;
    check_eq("rm_read_before", 64'(rd_s[0]), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rm_read_drop", 64'(rd_s[0]), 64'd0);
    check_eq("rm_ce", 64'(ce_s[0]), 64'd0);
    check_eq("rm_irdata", 64'(i_rdata_s[0]), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rm_idle_ce", 64'(ce_s[0]), 64'd0);
    check_eq("rm_idle_read", 64'(rd_s[0]), 64'd0);
    tick(); #1;
    check_eq("rm_reissue", 64'(rd_s[0]), 64'd1);
    check_eq("rm_reissue_addr", 64'(addr_s[0]), 64'h200);
    wait_s = 1'b0; rdata_s = 32'h0000_0055;
    tick(); #1;
    check_eq("rm_done_ce", 64'(ce_s[0]), 64'd1);
    check_eq("rm_done_irdata", 64'(i_rdata_s[0]), 64'h55);
    check_eq("rm_done_read", 64'(rd_s[0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Parametrised bridge between the stall-controlled Harvard core (separate instruction and data ports) and a single Avalon-MM master bus. It serialises instruction fetches, data reads and byte-enabled data writes with a configurable port priority, and holds each bus request stable across waitrequest. A one-word instruction buffer lets repeated fetches of the same address complete without a bus access. It replaces the fixed 32-bit, full-word-only bus wrapper around `mips_cpu_harvard`.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, a multiple of 8 and at least 16; `BE_W = DATA_W/8`.
- `DATA_FIRST`, 0: when 1, a pending data access wins over a pending fetch; when 0, the fetch wins.
- `IBUF_EN`, 1: when 1, the instruction buffer persists across fetches; when 0, it is invalidated on every advancing edge.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: asynchronous active-high reset.
- `i_read` in 1: core requests the instruction at `i_address`.
- `i_address` in ADDR_W: instruction byte address.
- `i_readdata` out DATA_W: fetched instruction.
- `d_read` in 1: data read request.
- `d_write` in 1: data write request.
- `d_address` in ADDR_W: data byte address.
- `d_byteenable` in BE_W: write lanes.
- `d_writedata` in DATA_W: write data.
- `d_readdata` out DATA_W: read result.
- `clk_enable` out 1: core may advance this cycle.
- `waitrequest` in 1: Avalon slave stall.
- `readdata` in DATA_W: Avalon read data.
- `read` out 1: Avalon read.
- `write` out 1: Avalon write.
- `address` out ADDR_W: Avalon address, word aligned.
- `byteenable` out BE_W: Avalon lane enables.
- `writedata` out DATA_W: Avalon write data.

## Operation
- FSM states are IDLE, IFETCH, DREAD and DWRITE. There is one outstanding transaction at most.
- Instruction hit: `ibuf_valid` is set and the stored address equals `i_address` with the low log2(BE_W) bits dropped.
- Pending conditions:
  - `i_pend` = `i_read` && !hit.
  - `d_pend` = (`d_read` || `d_write`) && !`d_done`.
- `clk_enable` = !`reset` && !`i_pend` && !`d_pend`.
- IDLE transitions:
  - If both ports are pending, choose the port by `DATA_FIRST`.
  - On the next edge, register `address`, `byteenable` and `writedata`, and assert `read` or `write`.
  - A data access where both `d_read` and `d_write` are set is treated as a read.
- Bus address: the low log2(BE_W) bits are always 0.
- Byte enables: reads drive all ones; writes drive `d_byteenable`.
- An all-zero `d_byteenable` write still issues a bus write.
- Bus request hold: `read`, `write`, `address`, `byteenable` and `writedata` stay constant while `waitrequest` is 1.
- Completion happens at the edge where the request is asserted and `waitrequest` is 0. At that edge:
  - IFETCH loads `readdata` and the address into the instruction buffer and sets `ibuf_valid`.
  - DREAD loads `readdata` into `d_rdata_q` and sets `d_done`.
  - DWRITE sets `d_done`.
  - The request is deasserted and the FSM returns to IDLE. There is always exactly one idle cycle between transactions.
- Readdata timing: `readdata` is valid in the same cycle that `waitrequest` is low.
- Read data outputs:
  - `i_readdata` is the instruction buffer data.
  - `d_readdata` is `d_rdata_q`.
- Advancing edge: any edge with `clk_enable`=1. On such an edge:
  - `d_done` is cleared.
  - If `IBUF_EN`=0, `ibuf_valid` is also cleared.
- Coherency: a completing DWRITE whose word address equals the buffered address clears `ibuf_valid`, regardless of byte enables.
- If the request inputs change while the FSM is busy, the in-flight transaction completes unchanged. The new inputs are evaluated in IDLE.

## Timing
- Reset values:
  - `read`=0, `write`=0.
  - `address`=0, `byteenable`=0, `writedata`=0.
  - `clk_enable`=0.
  - `ibuf_valid`=0, `d_done`=0, `d_rdata_q`=0; FSM in IDLE.
  - `i_readdata`=0 and `d_readdata`=0.
- Reset asserted mid-transaction drops `read` and `write` immediately and discards the transaction.
- Zero-wait fetch miss, with `i_pend` high in cycle N:
  - `read` is high in N+1.
  - The buffer is loaded at the end of N+1.
  - `clk_enable`=1 in N+2.
- Each waitrequest cycle adds one cycle to that sequence.
- A miss on both ports with zero waits gives `clk_enable` in N+4.
- A buffer hit with no data access gives `clk_enable`=1 in the same cycle, with zero latency.

## Structure
- Package `mips_bus_pkg`:
  - `state_t` enum covering IDLE, IFETCH, DREAD and DWRITE.
  - A function returning the word-aligned address for a given `DATA_W`.
- Sub-module `mips_ibuf` holds the address and data registers, the valid flag, hit compare, load, invalidate-on-write and the `IBUF_EN` clear.
- The FSM, request registers and `d_done` logic stay in the top module.

## Test plan
- Reset, then `i_read`=1, `i_address`=0xBFC00000 with zero waits: `read`=1 at address 0xBFC00000 one cycle later, `clk_enable` two cycles later, `i_readdata` equal to the slave word.
- The same `i_address` held over 3 advancing edges with `IBUF_EN`=1: no further `read`, `clk_enable` stays 1. With `IBUF_EN`=0: one `read` per instruction.
- Fetch miss plus `d_write` in the same cycle, `DATA_FIRST`=0 and then 1: bus order IFETCH→DWRITE and DWRITE→IFETCH respectively. `clk_enable` 4 cycles after the request in both cases.
- `waitrequest` held high for 5 cycles during DREAD at address 0x1003: `address`=0x1000 and `byteenable`=0xF stable for all 5 cycles. `d_readdata` is captured only at the release edge.
- `d_write` of 0x000000AB with `d_byteenable`=0x1 to the buffered instruction word: `byteenable`=0x1 on the bus and `ibuf_valid` cleared. The next identical fetch issues a `read`.
- `reset` asserted while `read`=1 and `waitrequest`=1: `read` drops asynchronously, and after release the fetch is re-issued from IDLE.
